ifetch_unit: RTL

//   Instruction-fetch initiator: generates sequential PCs, issues requests to the icache

---
 rtl/ifetch_unit_pkg.sv | 25 ++
 rtl/ifetch_unit_if.sv | 41 ++++
 rtl/ifetch_unit_fifo.sv | 64 ++++++
 rtl/ifetch_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch unit.
package ifetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } ifu_state_e;

    // One buffered instruction as presented to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: backend redirect, icache request/response, decode output.
// master = fetch unit side, slave = environment (icache + backend + decode).
interface ifetch_unit_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output req_valid, req_addr,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        output out_valid, out_pc, out_inst,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  req_valid, req_addr,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        input  out_valid, out_pc, out_inst,
        output out_ready
    );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// ifu_sync_fifo: synchronous FIFO with flush, occupancy count and full/empty flags.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module ifu_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential-PC instruction fetch initiator with response tagging,
// instruction buffer toward decode, and redirect flush/drain.
// Optional feature macro: IFETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rstn,
    ifetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_drop_cnt
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BW = $clog2(BUF_DEPTH + 1);

    ifu_state_e   state_q;
    logic [31:0]  fetch_pc_q;
    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] outstanding_d;
    logic [OW-1:0] drop_cnt_q;

    logic         credit_ok;
    logic         req_valid;
    logic         req_fire;
    logic         rsp_fire;
    logic         rsp_keep;
    logic         out_valid;
    logic         out_fire;

    logic [31:0]  tag_head;
    logic [OW-1:0] tag_count;
    logic         tag_full;
    logic         tag_empty;

    fetch_entry_t buf_wdata;
    fetch_entry_t buf_rdata;
    logic [BW-1:0] buf_count;
    logic         buf_full;
    logic         buf_empty;

    logic         unused_fifo_flags;

    // Buffer slots are reserved at request time, so the buffer can never overflow.
    assign credit_ok = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                       (32'(outstanding_q) + 32'(buf_count) < BUF_DEPTH);
    assign req_valid = (state_q == S_FETCH) && credit_ok && !bus.redirect_valid;
    assign req_fire  = req_valid && bus.req_ready;
    assign rsp_fire  = bus.rsp_valid && rstn;
    assign rsp_keep  = rsp_fire && (state_q == S_FETCH) && !bus.redirect_valid;
    assign out_valid = !buf_empty && !bus.redirect_valid;
    assign out_fire  = out_valid && bus.out_ready;

    assign bus.req_valid = req_valid;
    assign bus.req_addr  = fetch_pc_q;
    assign bus.rsp_ready = rstn;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = buf_rdata.pc;
    assign bus.out_inst  = buf_rdata.inst;

    assign buf_wdata.pc   = tag_head;
    assign buf_wdata.inst = bus.rsp_data;

    assign unused_fifo_flags = &{1'b0, tag_count, tag_full, tag_empty, buf_full};

    ifu_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (req_fire),
        .pop_i   (rsp_keep),
        .flush_i (bus.redirect_valid),
        .data_i  (fetch_pc_q),
        .data_o  (tag_head),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    ifu_sync_fifo #(
        .WIDTH (64),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rsp_keep),
        .pop_i   (out_fire),
        .flush_i (bus.redirect_valid),
        .data_i  (buf_wdata),
        .data_o  (buf_rdata),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Accepted-but-unanswered count; stale responses still retire a slot.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!req_fire && rsp_fire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    // Fetch FSM: PC generation, redirect capture and stale-response drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (bus.redirect_valid) begin
                // A response firing this cycle is already excluded from outstanding_d.
                fetch_pc_q <= bus.redirect_pc;
                drop_cnt_q <= outstanding_d;
                state_q    <= (outstanding_d != '0) ? S_DRAIN : S_FETCH;
            end else begin
                if (req_fire) fetch_pc_q <= next_pc(fetch_pc_q);
                unique case (state_q)
                    S_IDLE:  state_q <= S_FETCH;
                    S_FETCH: state_q <= S_FETCH;
                    S_DRAIN: begin
                        if (drop_cnt_q == '0) begin
                            state_q <= S_FETCH;
                        end else if (rsp_fire) begin
                            drop_cnt_q <= drop_cnt_q - OW'(1);
                            if (drop_cnt_q == OW'(1)) state_q <= S_FETCH;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;
    logic        rsp_drop;

    assign rsp_drop       = rsp_fire && !rsp_keep;
    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;

    // Delivered-instruction and discarded-work counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (out_fire) perf_fetch_q <= perf_fetch_q + 32'd1;
            perf_drop_q <= perf_drop_q + 32'(rsp_drop) +
                           (bus.redirect_valid ? 32'(buf_count) : 32'd0);
        end
    end
`endif

endmodule
